// File: rtl/oh_memory_bist_pkg.sv
// Shared types for the March C- memory BIST controller: run states, access
// phase encoding and the data background selector.
package oh_memory_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_R0W1  = 3'd2,
    S_R1W0  = 3'd3,
    S_R0    = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  // Read-modify elements alternate a read cycle with a write cycle.
  typedef enum logic {
    PH_READ  = 1'b0,
    PH_WRITE = 1'b1
  } phase_e;

  typedef enum logic {
    BG_ZEROS = 1'b0,
    BG_ONES  = 1'b1
  } bg_e;

  function automatic logic is_access(state_e s);
    return s inside {S_W0, S_R0W1, S_R1W0, S_R0};
  endfunction

  function automatic logic is_write(state_e s, phase_e p);
    return (s == S_W0) || ((s == S_R0W1 || s == S_R1W0) && p == PH_WRITE);
  endfunction

  function automatic bg_e write_bg(state_e s);
    return (s == S_R0W1) ? BG_ONES : BG_ZEROS;
  endfunction

  function automatic bg_e read_bg(state_e s);
    return (s == S_R1W0) ? BG_ONES : BG_ZEROS;
  endfunction

endpackage

// File: rtl/oh_bist_addrgen.sv
// Up/down BIST address counter with load, step and a terminal-count flag
// that marks DEPTH-1 when counting up and 0 when counting down.
module oh_bist_addrgen
  import oh_memory_bist_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_i,
  input  logic [AW-1:0] load_val_i,
  input  logic          step_i,
  input  logic          down_i,
  output logic [AW-1:0] addr_o,
  output logic          tc_o
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [AW-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_val_i;
    end else if (step_i) begin
      addr_d = down_i ? addr_q - AW'(1) : addr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = down_i ? (addr_q == '0) : (addr_q == LAST);

endmodule

// File: rtl/oh_memory_bist.sv
// March C- (simplified) BIST controller for a single-port memory.
// Define OH_MEMORY_BIST_FAILLOG_EN to log address and raw data of the first failing read.
module oh_memory_bist
  import oh_memory_bist_pkg::*;
#(
  parameter int DW    = 104,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic          bist_en,
  output logic          bist_we,
  output logic [DW-1:0] bist_wem,
  output logic [DW-1:0] bist_din,
  output logic [AW-1:0] bist_addr,
  input  logic [DW-1:0] dout,
  output logic          busy,
  output logic          done,
  output logic          fail,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic          bist_en_q, bist_we_q, busy_q, done_q, fail_q;
  logic [DW-1:0] bist_din_q;
  logic          rd_vld_q;
  bg_e           rd_bg_q;
  logic          accept, load, step, tc, mismatch;
  logic [AW-1:0] load_val, addr;

  assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    phase_d  = PH_READ;
    load     = 1'b0;
    load_val = '0;
    step     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_W0;
          load    = 1'b1;
        end
      end
      S_W0: begin
        if (tc) begin
          state_d = S_R0W1;
          load    = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      S_R0W1, S_R1W0: begin
        if (phase_q == PH_READ) begin
          phase_d = PH_WRITE;
        end else if (!tc) begin
          step = 1'b1;
        end else begin
          load     = 1'b1;
          state_d  = (state_q == S_R0W1) ? S_R1W0 : S_R0;
          load_val = (state_q == S_R0W1) ? LAST : '0;
        end
      end
      S_R0: begin
        if (tc) begin
          state_d = S_DRAIN;
          load    = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  oh_bist_addrgen #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_addrgen (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .load_val_i(load_val),
    .step_i    (step),
    .down_i    (state_q == S_R1W0),
    .addr_o    (addr),
    .tc_o      (tc)
  );

  // Read data arrives one cycle after the read access; compare it then.
  assign mismatch = rd_vld_q && (dout != {DW{rd_bg_q == BG_ONES}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_READ;
      bist_en_q  <= 1'b0;
      bist_we_q  <= 1'b0;
      bist_din_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      rd_vld_q   <= 1'b0;
      rd_bg_q    <= BG_ZEROS;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      bist_en_q  <= is_access(state_d);
      bist_we_q  <= is_write(state_d, phase_d);
      bist_din_q <= {DW{write_bg(state_d) == BG_ONES}};
      busy_q     <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q     <= (state_d == S_DONE);
      rd_vld_q   <= bist_en_q && !bist_we_q;
      rd_bg_q    <= read_bg(state_q);
      if (accept) begin
        fail_q <= 1'b0;
      end else if (mismatch) begin
        fail_q <= 1'b1;
      end
    end
  end

`ifdef OH_MEMORY_BIST_FAILLOG_EN
  logic [AW-1:0] rd_addr_q, fail_addr_q;
  logic [DW-1:0] fail_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      rd_addr_q <= addr;
      if (accept) begin
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch && !fail_q) begin
        fail_addr_q <= rd_addr_q;
        fail_data_q <= dout;
      end
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

  assign bist_en   = bist_en_q;
  assign bist_we   = bist_we_q;
  assign bist_wem  = {DW{bist_we_q}};
  assign bist_din  = bist_din_q;
  assign bist_addr = addr;
  assign busy      = busy_q;
  assign done      = done_q;
  assign fail      = fail_q;

endmodule
